joystick_spi_reader: RTL and testbench

Polls a PmodJSTK-style two-axis joystick over SPI (mode 0) and produces the 4-bit per-axis velocity codes consumed by the bouncing-ball position stage. The block sits directly upstream of that stage and drives its `x_axis`/`y_axis` inputs. It also exposes full 10-bit samples, button state and a sample-valid strobe for debug and other consumers.

---
 rtl/joystick_spi_reader.sv | 196 +++++++++++++++++++
 tb/tb_joystick_spi_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_spi_reader.sv
// SPI mode-0 poller for a PmodJSTK-style joystick. One 5-byte exchange per poll
// period latches 10-bit X/Y samples, buttons and the 4-bit ball velocity codes.
module joystick_spi_reader #(
    parameter int HALF_SCLK   = 50,
    parameter int SS_SETUP    = 1500,
    parameter int BYTE_GAP    = 1000,
    parameter int POLL_PERIOD = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] leds,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss_n,
    output logic [3:0] x_axis,
    output logic [3:0] y_axis,
    output logic [9:0] x_raw,
    output logic [9:0] y_raw,
    output logic [2:0] buttons,
    output logic       sample_valid,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int CNT_MAX0 = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
    localparam int CNT_MAX  = (CNT_MAX0 > HALF_SCLK) ? CNT_MAX0 : HALF_SCLK;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int POLL_W   = $clog2(POLL_PERIOD);

    localparam logic [CNT_W-1:0]  SETUP_LAST = CNT_W'(SS_SETUP - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST  = CNT_W'(HALF_SCLK - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST   = CNT_W'(BYTE_GAP - 1);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
    localparam logic [9:0]        X_CENTER   = 10'd448;
    localparam logic [9:0]        Y_CENTER   = 10'd512;

    state_t              r_state;
    state_t              w_next_state;
    logic [POLL_W-1:0]   r_poll_cnt;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_idx;
    logic [2:0]          r_bit;
    logic                r_sclk;
    logic                r_ss_n;
    logic [7:0]          r_tx_sr;
    logic [7:0]          r_rx_sr;
    logic [7:0]          r_b0;
    logic [1:0]          r_b1;
    logic [7:0]          r_b2;
    logic [1:0]          r_b3;
    logic [2:0]          r_b4;
    logic [9:0]          r_x_raw;
    logic [9:0]          r_y_raw;
    logic [2:0]          r_buttons;
    logic                r_sample_valid;

    logic                w_poll_wrap;
    logic                w_cnt_last;
    logic                w_sclk_rise;
    logic                w_sclk_fall;
    logic                w_byte_end;

    always_comb begin
        w_next_state = r_state;
        w_poll_wrap  = (r_poll_cnt == POLL_LAST);
        w_cnt_last   = 1'b0;
        w_sclk_rise  = 1'b0;
        w_sclk_fall  = 1'b0;
        w_byte_end   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_poll_wrap) w_next_state = ST_SETUP;
            end
            ST_SETUP: begin
                w_cnt_last = (r_cnt == SETUP_LAST);
                if (w_cnt_last) w_next_state = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_cnt_last  = (r_cnt == HALF_LAST);
                w_sclk_rise = w_cnt_last && !r_sclk;
                w_sclk_fall = w_cnt_last && r_sclk;
                w_byte_end  = w_sclk_fall && (r_bit == 3'd7);
                if (w_byte_end) w_next_state = (r_idx == 3'd4) ? ST_DONE : ST_GAP;
            end
            ST_GAP: begin
                w_cnt_last = (r_cnt == GAP_LAST);
                if (w_cnt_last) w_next_state = ST_SHIFT;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_poll_cnt     <= '0;
            r_cnt          <= '0;
            r_idx          <= 3'd0;
            r_bit          <= 3'd0;
            r_sclk         <= 1'b0;
            r_ss_n         <= 1'b1;
            r_tx_sr        <= 8'h00;
            r_rx_sr        <= 8'h00;
            r_b0           <= 8'h00;
            r_b1           <= 2'b00;
            r_b2           <= 8'h00;
            r_b3           <= 2'b00;
            r_b4           <= 3'b000;
            r_x_raw        <= X_CENTER;
            r_y_raw        <= Y_CENTER;
            r_buttons      <= 3'b000;
            r_sample_valid <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            // Free-running so transaction starts stay on a fixed POLL_PERIOD grid.
            r_poll_cnt     <= w_poll_wrap ? '0 : r_poll_cnt + 1'b1;
            if (w_cnt_last || (w_next_state != r_state)) r_cnt <= '0;
            else if (r_state != ST_IDLE)                 r_cnt <= r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_poll_wrap) begin
                        r_ss_n  <= 1'b0;
                        r_tx_sr <= {1'b1, 5'b00000, leds};
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_last) begin
                        r_idx <= 3'd0;
                        r_bit <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_sclk  <= 1'b1;
                        r_rx_sr <= {r_rx_sr[6:0], miso};
                    end
                    if (w_sclk_fall) begin
                        r_sclk  <= 1'b0;
                        r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                        r_bit   <= r_bit + 3'd1;
                    end
                    // Only the bits that reach an output are kept from bytes 1, 3 and 4.
                    if (w_byte_end) begin
                        case (r_idx)
                            3'd0:    r_b0 <= r_rx_sr;
                            3'd1:    r_b1 <= r_rx_sr[1:0];
                            3'd2:    r_b2 <= r_rx_sr;
                            3'd3:    r_b3 <= r_rx_sr[1:0];
                            default: r_b4 <= r_rx_sr[2:0];
                        endcase
                    end
                end
                ST_GAP: begin
                    if (w_cnt_last) r_idx <= r_idx + 3'd1;
                end
                ST_DONE: begin
                    r_ss_n         <= 1'b1;
                    r_x_raw        <= {r_b1, r_b0};
                    r_y_raw        <= {r_b3, r_b2};
                    r_buttons      <= r_b4;
                    r_sample_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sclk         = r_sclk;
    assign mosi         = r_tx_sr[7];
    assign ss_n         = r_ss_n;
    assign x_raw        = r_x_raw;
    assign y_raw        = r_y_raw;
    assign x_axis       = r_x_raw[9:6];
    assign y_axis       = r_y_raw[9:6];
    assign buttons      = r_buttons;
    assign sample_valid = r_sample_valid;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_joystick_spi_reader.sv
// Directed bench for joystick_spi_reader with a behavioural SPI mode-0 joystick
// slave, using short timing parameters so whole transactions fit in a few hundred clocks.
module tb_joystick_spi_reader;
    localparam int H   = 2;
    localparam int S   = 4;
    localparam int G   = 4;
    localparam int P   = 200;
    localparam int CLK = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] leds  = 2'b00;
    logic       miso;
    logic       sclk;
    logic       mosi;
    logic       ss_n;
    logic [3:0] x_axis;
    logic [3:0] y_axis;
    logic [9:0] x_raw;
    logic [9:0] y_raw;
    logic [2:0] buttons;
    logic       sample_valid;
    logic [2:0] dbg_state;

    int checks  = 0;
    int errors  = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    joystick_spi_reader #(
        .HALF_SCLK(H), .SS_SETUP(S), .BYTE_GAP(G), .POLL_PERIOD(P)
    ) dut (
        .clock(clock), .reset(reset), .leds(leds), .miso(miso),
        .sclk(sclk), .mosi(mosi), .ss_n(ss_n),
        .x_axis(x_axis), .y_axis(y_axis), .x_raw(x_raw), .y_raw(y_raw),
        .buttons(buttons), .sample_valid(sample_valid), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #(CLK / 2) clock = ~clock;
    always @(posedge clock) cyc++;

    // ---------------- joystick slave ----------------
    logic [7:0] slv_tx [5];
    logic [7:0] slv_rx [5];
    logic [7:0] slv_cur    = 8'h00;
    logic       slv_active = 1'b0;
    int         slv_byte   = 0;
    int         slv_bit    = 0;
    logic [7:0] rx_sr      = 8'h00;
    int         rise_cnt   = 0;
    int         mosi_viol  = 0;
    logic       mosi_d     = 1'b0;

    assign miso = slv_cur[7];

    // miso presents the MSB on select, then shifts on each SCLK falling edge.
    always @(ss_n or negedge sclk) begin
        if (ss_n !== 1'b0) begin
            slv_active = 1'b0;
        end else if (!slv_active) begin
            slv_active = 1'b1;
            slv_byte   = 0;
            slv_bit    = 0;
            slv_cur    = slv_tx[0];
        end else if (sclk === 1'b0) begin
            slv_cur = {slv_cur[6:0], 1'b0};
            slv_bit++;
            if (slv_bit == 8) begin
                slv_bit = 0;
                slv_byte++;
                if (slv_byte < 5) slv_cur = slv_tx[slv_byte];
            end
        end
    end

    always @(posedge clock) mosi_d = mosi;

    always @(posedge sclk or negedge ss_n) begin
        if (sclk !== 1'b1) begin
            rise_cnt = 0;
        end else if (ss_n === 1'b0) begin
            rx_sr = {rx_sr[6:0], mosi};
            rise_cnt++;
            if ((rise_cnt % 8 == 0) && (rise_cnt <= 40)) slv_rx[rise_cnt / 8 - 1] = rx_sr;
            if (mosi !== mosi_d) mosi_viol++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic load_slave(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
        slv_tx[0] = b0; slv_tx[1] = b1; slv_tx[2] = b2; slv_tx[3] = b3; slv_tx[4] = b4;
    endtask

    // Waits for one whole select window; returns at the first negedge with ss_n high.
    task automatic wait_txn(output int fall_cyc, output int low_cnt, output int pulses,
                            output int raw_changes, output bit ok);
        int n;
        logic [22:0] snap;
        ok = 1'b1; fall_cyc = 0; low_cnt = 0; pulses = 0; raw_changes = 0; n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ss_n !== 1'b0 && n < 500);
        if (ss_n !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        fall_cyc = cyc;
        snap = {x_raw, y_raw, buttons};
        n = 0;
        while (ss_n === 1'b0 && n < 500) begin
            low_cnt++;
            if (sample_valid === 1'b1) pulses++;
            if ({x_raw, y_raw, buttons} !== snap) raw_changes++;
            @(negedge clock);
            n++;
        end
        if (ss_n !== 1'b1) ok = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        repeat (5) @(negedge clock);
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL rst_ss_n: got %b expected 1", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi: got %b expected 0", mosi); end
        checks++; if (x_raw !== 10'd448) begin errors++; $display("FAIL rst_x_raw: got %0d expected 448", x_raw); end
        checks++; if (y_raw !== 10'd512) begin errors++; $display("FAIL rst_y_raw: got %0d expected 512", y_raw); end
        checks++; if (buttons !== 3'd0) begin errors++; $display("FAIL rst_buttons: got %0d expected 0", buttons); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", sample_valid); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        reset   = 1'b1;
        rel_cyc = cyc;
        @(negedge clock);
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL rel_ss_n: got %b expected 1", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rel_sclk: got %b expected 0", sclk); end
        checks++; if (x_axis !== 4'd7) begin errors++; $display("FAIL rel_x_axis: got %0d expected 7", x_axis); end
        checks++; if (y_axis !== 4'd8) begin errors++; $display("FAIL rel_y_axis: got %0d expected 8", y_axis); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL rel_valid: got %b expected 0", sample_valid); end
    endtask

    task automatic test_full_transaction;
        int fall, low, pulses, chg, viol0;
        bit ok;
        load_slave(8'hFF, 8'h03, 8'h00, 8'h02, 8'h05);
        leds  = 2'b10;
        viol0 = mosi_viol;
        wait_txn(fall, low, pulses, chg, ok);
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: got ss_n %b expected a complete transaction", ss_n); end
        checks++; if (fall - rel_cyc != P) begin errors++; $display("FAIL full_first_start: got %0d expected %0d", fall - rel_cyc, P); end
        checks++; if (low != 181) begin errors++; $display("FAIL full_ss_low: got %0d expected 181", low); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL full_early_valid: got %0d expected 0", pulses); end
        checks++; if (chg != 0) begin errors++; $display("FAIL full_early_update: got %0d expected 0", chg); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %b expected 1", sample_valid); end
        checks++; if (x_raw !== 10'd1023) begin errors++; $display("FAIL full_x_raw: got %0d expected 1023", x_raw); end
        checks++; if (x_axis !== 4'd15) begin errors++; $display("FAIL full_x_axis: got %0d expected 15", x_axis); end
        checks++; if (y_raw !== 10'd512) begin errors++; $display("FAIL full_y_raw: got %0d expected 512", y_raw); end
        checks++; if (y_axis !== 4'd8) begin errors++; $display("FAIL full_y_axis: got %0d expected 8", y_axis); end
        checks++; if (buttons !== 3'd5) begin errors++; $display("FAIL full_buttons: got %0d expected 5", buttons); end
        checks++; if (rise_cnt != 40) begin errors++; $display("FAIL full_sclk_rises: got %0d expected 40", rise_cnt); end
        checks++; if ({slv_rx[0], slv_rx[1], slv_rx[2], slv_rx[3], slv_rx[4]} !== 40'h8200000000) begin
            errors++;
            $display("FAIL full_mosi_bytes: got %h %h %h %h %h expected 82 00 00 00 00",
                     slv_rx[0], slv_rx[1], slv_rx[2], slv_rx[3], slv_rx[4]);
        end
        checks++; if (mosi_viol != viol0) begin errors++; $display("FAIL full_mosi_stable: got %0d changes at SCLK rise expected 0", mosi_viol - viol0); end
        @(negedge clock);
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL full_valid_width: got %b expected 0", sample_valid); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL full_state_idle: got %0d expected 0", dbg_state); end
        rel_cyc = fall;
    endtask

    task automatic test_second_pattern;
        int fall, low, pulses, chg;
        bit ok;
        load_slave(8'h34, 8'hFE, 8'hC0, 8'hFC, 8'hFA);
        leds = 2'b01;
        wait_txn(fall, low, pulses, chg, ok);
        checks++; if (!ok) begin errors++; $display("FAIL pat2_timeout: got ss_n %b expected a complete transaction", ss_n); end
        checks++; if (fall - rel_cyc != P) begin errors++; $display("FAIL pat2_poll_period: got %0d expected %0d", fall - rel_cyc, P); end
        checks++; if (low != 181) begin errors++; $display("FAIL pat2_ss_low: got %0d expected 181", low); end
        checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL pat2_valid: got %b expected 1", sample_valid); end
        checks++; if (x_raw !== 10'd564) begin errors++; $display("FAIL pat2_x_raw: got %0d expected 564", x_raw); end
        checks++; if (x_axis !== 4'd8) begin errors++; $display("FAIL pat2_x_axis: got %0d expected 8", x_axis); end
        checks++; if (y_raw !== 10'd192) begin errors++; $display("FAIL pat2_y_raw: got %0d expected 192", y_raw); end
        checks++; if (y_axis !== 4'd3) begin errors++; $display("FAIL pat2_y_axis: got %0d expected 3", y_axis); end
        checks++; if (buttons !== 3'd2) begin errors++; $display("FAIL pat2_buttons: got %0d expected 2", buttons); end
        checks++; if (slv_rx[0] !== 8'h81) begin errors++; $display("FAIL pat2_mosi_byte0: got %h expected 81", slv_rx[0]); end
    endtask

    task automatic test_reset_abort;
        int n, fall, low, pulses, chg;
        bit ok;
        load_slave(8'h64, 8'h00, 8'h00, 8'h02, 8'h00);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(ss_n === 1'b0 && slv_byte == 2) && n < 500);
        checks++; if (!(ss_n === 1'b0 && slv_byte == 2)) begin errors++; $display("FAIL abort_reach_byte2: got byte %0d expected 2", slv_byte); end
        repeat (6) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++; if (x_raw !== 10'd448) begin errors++; $display("FAIL abort_x_raw: got %0d expected 448", x_raw); end
        checks++; if (y_raw !== 10'd512) begin errors++; $display("FAIL abort_y_raw: got %0d expected 512", y_raw); end
        checks++; if (buttons !== 3'd0) begin errors++; $display("FAIL abort_buttons: got %0d expected 0", buttons); end
        checks++; if (ss_n !== 1'b1) begin errors++; $display("FAIL abort_ss_n: got %b expected 1", ss_n); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", sample_valid); end
        repeat (4) @(negedge clock);
        reset   = 1'b1;
        rel_cyc = cyc;
        wait_txn(fall, low, pulses, chg, ok);
        checks++; if (!ok) begin errors++; $display("FAIL abort_retry_timeout: got ss_n %b expected a complete transaction", ss_n); end
        checks++; if (fall - rel_cyc != P) begin errors++; $display("FAIL abort_restart: got %0d expected %0d", fall - rel_cyc, P); end
        checks++; if (x_raw !== 10'd100) begin errors++; $display("FAIL abort_retry_x_raw: got %0d expected 100", x_raw); end
        checks++; if (x_axis !== 4'd1) begin errors++; $display("FAIL abort_retry_x_axis: got %0d expected 1", x_axis); end
        checks++; if (y_raw !== 10'd512) begin errors++; $display("FAIL abort_retry_y_raw: got %0d expected 512", y_raw); end
    endtask

    task automatic test_ball_integration;
        int fall, low, pulses, chg, pos_x, pos_y;
        bit ok;
        load_slave(8'hC0, 8'h01, 8'h00, 8'h02, 8'h00);
        wait_txn(fall, low, pulses, chg, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ball_timeout: got ss_n %b expected a complete transaction", ss_n); end
        checks++; if (x_raw !== 10'd448) begin errors++; $display("FAIL ball_x_raw: got %0d expected 448", x_raw); end
        checks++; if (x_axis !== 4'd7) begin errors++; $display("FAIL ball_x_axis: got %0d expected 7", x_axis); end
        checks++; if (y_axis !== 4'd8) begin errors++; $display("FAIL ball_y_axis: got %0d expected 8", y_axis); end
        // Downstream ball stage: 7 on X and 8 on Y are the zero-velocity codes.
        pos_x = 320;
        pos_y = 240;
        repeat (3) begin
            repeat (16) @(negedge clock);
            pos_x = pos_x + int'(x_axis) - 7;
            pos_y = pos_y + int'(y_axis) - 8;
        end
        checks++; if (pos_x != 320) begin errors++; $display("FAIL ball_pos_x: got %0d expected 320", pos_x); end
        checks++; if (pos_y != 240) begin errors++; $display("FAIL ball_pos_y: got %0d expected 240", pos_y); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        load_slave(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_full_transaction();
        test_second_pattern();
        test_reset_abort();
        test_ball_integration();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #(CLK * 20000);
        $display("FAIL watchdog: got no completion expected finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end
endmodule
